// File: rtl/fetch_queue.sv
// Instruction fetch queue: a single-outstanding-request fetch engine feeding a
// DEPTH-entry circular FIFO of {pc, instr} pairs toward decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       valid_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                instr_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic          inflight_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic [CW:0]   occupancy_s;
    logic          req_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [31:0]   redirect_aligned_s;

    // Credit check counts the in-flight word so a returning response always has a slot.
    always_comb begin
        occupancy_s        = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        valid_s            = (count_r != {CW{1'b0}});
        push_s             = 1'b0;
        pop_s              = 1'b0;
        req_s              = 1'b0;
        redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
        if (!reset && !redirect_valid && (occupancy_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (!redirect_valid) begin
            push_s = inflight_r;
            pop_s  = valid_s && ready_in;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Control state: fetch PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0;
            inflight_r <= 1'b0;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_aligned_s;
            inflight_r <= 1'b0;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (req_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                req_pc_r   <= fetch_pc_r;
                inflight_r <= 1'b1;
            end else begin
                inflight_r <= 1'b0;
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= req_pc_r;
            instr_mem_r[tail_r] <= imem_rdata;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign valid_out = valid_s;
    assign pc_out    = pc_mem_r[head_r];
    assign instr_out = instr_mem_r[head_r];
    assign count_out = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4) with a one-cycle
// latency instruction memory that returns address XOR a key.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        ready_in;
    logic [2:0]  count_out;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_out      (valid_out),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .ready_in       (ready_in),
        .count_out      (count_out)
    );

    always #5 clk = ~clk;

    // Unrequested cycles return garbage so a spurious push is visible.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rdy   rv    rpc           req   addr          valid pc            count
        vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h000,      1'b0, 32'h0,        3'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h004,      1'b0, 32'h0,        3'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h008,      1'b1, 32'h000,      3'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h00C,      1'b1, 32'h004,      3'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h010,      1'b1, 32'h008,      3'd1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h014,      1'b1, 32'h008,      3'd2};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h018,      1'b1, 32'h008,      3'd3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h018,      1'b1, 32'h00C,      3'd3};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h01C,      1'b1, 32'h00C,      3'd3};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h01C,      1'b1, 32'h00C,      3'd4};
        vecs[10] = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h01C,      1'b1, 32'h00C,      3'd4};
        vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h01C,      1'b1, 32'h010,      3'd3};
        vecs[12] = '{1'b1, 1'b1, 32'h103,     1'b0, 32'h020,      1'b1, 32'h010,      3'd3};
        vecs[13] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, 32'h0,        3'd0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h104,      1'b0, 32'h0,        3'd0};
        vecs[15] = '{1'b1, 1'b1, 32'h200,     1'b0, 32'h108,      1'b1, 32'h100,      3'd1};
        vecs[16] = '{1'b0, 1'b1, 32'h300,     1'b0, 32'h200,      1'b0, 32'h0,        3'd0};
        vecs[17] = '{1'b0, 1'b1, 32'h407,     1'b0, 32'h300,      1'b0, 32'h0,        3'd0};
        vecs[18] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h404,      1'b0, 32'h0,        3'd0};
        vecs[19] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h408,      1'b0, 32'h0,        3'd0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h40C,      1'b1, 32'h404,      3'd1};
        vecs[21] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h410,      1'b1, 32'h404,      3'd2};
        vecs[22] = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h414,      1'b1, 32'h404,      3'd3};
        vecs[23] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h414,      1'b1, 32'h408,      3'd3};

        reset          = 1'b1;
        ready_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        tick();
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset count_out", 32'(count_out), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            ready_in       = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            end
            chk($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d count_out", i), 32'(count_out), 32'(vecs[i].e_count));
            if (vecs[i].e_valid) begin
                chk($sformatf("row%0d pc_out", i), pc_out, vecs[i].e_pc);
                chk($sformatf("row%0d instr_out", i), instr_out, vecs[i].e_pc ^ KEY);
            end
            tick();
        end

        // Fetch PC wraps from the top of the address space to zero.
        ready_in       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap first addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap first req", 32'(imem_req), 32'd1);
        tick();
        chk("wrap second addr", imem_addr, 32'h0000_0000);
        tick();
        chk("wrap valid", 32'(valid_out), 32'd1);
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap instr_out", instr_out, 32'hFFFF_FFFC ^ KEY);
        tick();
        chk("wrap next pc_out", pc_out, 32'h0000_0000);
        chk("wrap count", 32'(count_out), 32'd1);

        // Asynchronous reset in mid-cycle with entries and a request outstanding.
        #2;
        reset = 1'b1;
        #1;
        chk("async valid_out", 32'(valid_out), 32'd0);
        chk("async imem_req", 32'(imem_req), 32'd0);
        chk("async count_out", 32'(count_out), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post-reset req", 32'(imem_req), 32'd1);
        chk("post-reset addr", imem_addr, 32'h0);
        chk("post-reset valid", 32'(valid_out), 32'd0);
        tick();
        chk("post-reset addr2", imem_addr, 32'h4);
        chk("post-reset valid2", 32'(valid_out), 32'd0);
        tick();
        chk("post-reset valid3", 32'(valid_out), 32'd1);
        chk("post-reset pc_out", pc_out, 32'h0);
        chk("post-reset instr_out", instr_out, 32'h0 ^ KEY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
